// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO with occupancy count,
//                programmable almost-full/almost-empty thresholds, overflow
//                and underflow error pulses, and a build-time FWFT mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       WREN,
  input  logic                       RDEN,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_af_level = c_cnt_w'(AF_LEVEL);
  localparam logic [c_cnt_w-1:0] c_ae_level = c_cnt_w'(AE_LEVEL);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               overflow_q, underflow_q;
  logic               w_rd_ok, w_wr_ok;

  // Flags derive only from the count register, never from pointer compares.
  assign empty        = (count_q == '0);
  assign full         = (count_q == c_depth);
  assign almost_full  = (count_q >= c_af_level);
  assign almost_empty = (count_q <= c_ae_level);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read on a full FIFO frees the slot the concurrent write lands in.
  assign w_rd_ok = RDEN && !empty;
  assign w_wr_ok = WREN && (!full || w_rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_ok) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end
    if (w_rd_ok) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
    case ({w_wr_ok, w_rd_ok})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= WREN && !w_wr_ok;
      underflow_q <= RDEN && !w_rd_ok;
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
        end else if (w_rd_ok) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Self-checking bench for sync_fifo_param (standard and FWFT
//                builds driven in lockstep against a queue reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = DEPTH - 2;
  localparam int AE_LVL = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wren = 1'b0;
  logic              rden = 1'b0;
  logic [DATA_W-1:0] din = '0;

  logic [DATA_W-1:0] s_dout, f_dout;
  logic              s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic              f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0]        s_count, f_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  bit                m_ovf = 1'b0;
  bit                m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .WREN(wren), .RDEN(rden), .data_in(din),
    .data_out(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .WREN(wren), .RDEN(rden), .data_in(din),
    .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("std.count",   32'(s_count), 32'(n));
    chk("std.full",    32'(s_full),  32'(n == DEPTH));
    chk("std.empty",   32'(s_empty), 32'(n == 0));
    chk("std.afull",   32'(s_af),    32'(n >= AF_LVL));
    chk("std.aempty",  32'(s_ae),    32'(n <= AE_LVL));
    chk("std.ovf",     32'(s_ovf),   32'(m_ovf));
    chk("std.unf",     32'(s_unf),   32'(m_unf));
    chk("std.dout",    32'(s_dout),  32'(m_dout));
    chk("fwft.count",  32'(f_count), 32'(n));
    chk("fwft.flags",  {28'd0, f_full, f_empty, f_af, f_ae},
        {28'd0, n == DEPTH, n == 0, n >= AF_LVL, n <= AE_LVL});
    chk("fwft.err",    {30'd0, f_ovf, f_unf}, {30'd0, m_ovf, m_unf});
    if (n > 0) chk("fwft.dout", 32'(f_dout), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic step(input bit r, input bit w, input bit rd, input logic [DATA_W-1:0] d);
    bit rd_ok, wr_ok;
    rst = r; wren = w; rden = rd; din = d;
    rd_ok = rd && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_ovf = w && !wr_ok;
      m_unf = rd && !rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    step(1, 1, 1, 8'h33);
    step(1, 0, 0, 8'h00);

    // Fill 1..16, then a 17th write overflows
    for (int i = 1; i <= DEPTH; i++) step(0, 1, 0, DATA_W'(i));
    step(0, 1, 0, 8'h77);
    step(0, 0, 0, 8'h00);

    // Drain 16, then one extra read underflows and data_out holds
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Simultaneous write+read at full, then drain to confirm ordering
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DATA_W'(8'h40 + i));
    step(0, 1, 1, 8'hEE);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);

    // Simultaneous write+read at empty: write lands, read underflows
    step(0, 1, 1, 8'h5C);
    step(0, 0, 1, 8'h00);

    // Wrap: three rounds of write-10 / read-10
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(0, 1, 0, DATA_W'(r * 10 + i + 1));
      for (int i = 0; i < 10; i++) step(0, 0, 1, 8'h00);
    end

    // FWFT fall-through of a single word, then pop
    step(0, 1, 0, 8'hA5);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);

    // Reset with nine entries, then fresh data must come back
    for (int i = 0; i < 9; i++) step(0, 1, 0, DATA_W'(8'h90 + i));
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h3C);
    step(0, 0, 1, 8'h00);

    // Randomised traffic with shifting bias to visit both full and empty
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 100) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < wp),
           ($urandom_range(0, 99) < (100 - wp)),
           DATA_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, successor to the fixed 8-bit FIFO, for buffering byte and word streams between producer and consumer blocks in the same clock domain. It adds:
- configurable data width and depth;
- programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- overflow and underflow error pulses;
- a build-time first-word-fall-through (FWFT) mode.

## Interface
- DATA_W, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered-read mode, 1 = first-word-fall-through mode

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- WREN  in  1  write request
- RDEN  in  1  read request
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×DATA_W register array, no reset on contents.
- Pointers: write and read pointers, $clog2(DEPTH) bits each, wrap naturally modulo DEPTH.
- count: a dedicated register; pointers are not compared to derive it.
- Status flags: full, empty, almost_full and almost_empty are pure functions of the count register.
- Read acceptance:
  - rd_ok = RDEN && !empty.
- Write acceptance:
  - wr_ok = WREN && (!full || rd_ok).
  - When full, a simultaneous accepted read frees the slot, so both operations succeed.
- Count update:
  - count += 1 on wr_ok only.
  - count −= 1 on rd_ok only.
  - count is unchanged when both or neither occur.
- Empty with WREN and RDEN together:
  - the write is accepted;
  - the read is rejected;
  - underflow pulses.
- Error pulses:
  - overflow = registered (WREN && !wr_ok).
  - underflow = registered (RDEN && !rd_ok).
  - The pointers and count are never corrupted by rejected requests.
- Standard mode (FWFT=0):
  - On rd_ok, data_out registers mem[rd_ptr].
  - data_out otherwise holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] continuously; it is valid whenever !empty.
  - RDEN acts as a pop/acknowledge of the word currently shown.
  - data_out is don't-care while empty.
- Reset (rst=1 at a rising edge):
  - Pointer and count state: pointers=0, count=0.
  - Flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - Error pulses: overflow=0, underflow=0.
  - data_out: 0 in standard mode.
  - Reset overrides any concurrent WREN or RDEN.
  - Contents in flight are discarded.

## Timing
- Write latency: a write accepted at edge N is reflected in count and flags after edge N.
  - In FWFT mode, a write into an empty FIFO is visible on data_out after edge N.
- Standard-mode read latency: RDEN accepted at edge M gives valid data_out after edge M, i.e. one cycle.
- Error timing: overflow and underflow are high for exactly the cycle after the offending edge.
- Reset mid-operation: the outputs take their reset values after the first edge with rst=1.
  - Normal operation resumes on the first edge with rst=0.
- Wrap-around: after DEPTH writes and DEPTH reads, both pointers return to 0; ordering is preserved across the wrap.

## Test plan
- Fill (DEPTH=16, standard mode): write 1..16 on consecutive cycles.
  - count steps 1..16; almost_full rises at count 14; full=1 after the 16th write.
  - A 17th WREN gives overflow=1 for one cycle and count stays 16.
- Drain: read 16 times, then one more read.
  - data_out sequence is 1..16, each valid one cycle after its RDEN.
  - almost_empty rises at count 2; empty=1 after the 16th read.
  - The extra read gives an underflow pulse and data_out holds 16.
- Simultaneous operations:
  - At full, WREN+RDEN together → count stays 16, no overflow, and the written word appears after the 15 older words.
  - At empty, WREN+RDEN together → count=1 and an underflow pulse.
- Wrap: 3 rounds of write-10/read-10 with incrementing data → output order is exactly the input order, and pointers wrap without data loss.
- FWFT=1: write 0xA5 into the empty FIFO.
  - data_out=0xA5 after that edge with no RDEN.
  - RDEN then pops it and empty=1.
- Reset with count=9: assert rst for one cycle → count=0, empty=1, almost_empty=1, full=0, no error pulse.
  - A subsequent write/read returns the new data, not stale data.
